// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Shows a 32-bit value as 8 hex nibbles, digit 0 rightmost. A new value is captured into a
// shadow register on load. It moves to the displayed register only at a frame boundary,
// so a digit never shows part of an old value and part of a new one.
// Optional feature: define SEG7_BLANK_LEADING_ZERO_EN to blank leading zero digits.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic [7:0]  digit_mask,
  input  logic [7:0]  dp_mask,
  output logic        pending,
  output logic        frame_tick,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned PW = $clog2(SCAN_DIV + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [31:0]   shadow;
  logic [31:0]   disp;

  logic          slot_end_c;
  logic          frame_end_c;
  logic          blank_c;
  logic          lit_c;
  logic [3:0]    nib_c;

  // Active-low hex decode, segment order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign slot_end_c  = (presc == PRESC_MAX);
  assign frame_end_c = slot_end_c && (idx == 3'd7);
  assign nib_c       = disp[{idx, 2'b00} +: 4];

`ifdef SEG7_BLANK_LEADING_ZERO_EN
  logic [2:0] msn_c;

  // Locate the most significant nonzero nibble; digits above it are blanked (digit 0 never is)
  always_comb begin
    msn_c = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (disp[4*k +: 4] != 4'h0) msn_c = 3'(k);
    end
    blank_c = (idx != 3'd0) && (idx > msn_c);
  end
`else
  assign blank_c = 1'b0;
`endif

  assign lit_c = digit_mask[idx] & ~blank_c;

  // Slot prescaler and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      idx        <= 3'd0;
      frame_tick <= 1'b0;
    end else begin
      presc      <= slot_end_c ? '0 : presc + PW'(1);
      if (slot_end_c) idx <= idx + 3'd1;
      frame_tick <= frame_end_c;
    end
  end

  // Shadow capture and frame-boundary transfer; a load that lands on frame_end waits a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= 32'h0;
      disp    <= 32'h0;
      pending <= 1'b0;
    end else begin
      if (frame_end_c && pending) disp <= shadow;
      if (load) begin
        shadow  <= data_in;
        pending <= 1'b1;
      end else if (frame_end_c) begin
        pending <= 1'b0;
      end
    end
  end

  // Registered display outputs, one cycle behind idx/disp
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= lit_c ? ~(8'b1 << idx) : 8'hFF;
      seg <= hex_decode(nib_c);
      dp  <= ~(dp_mask[idx] & lit_c);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench for seg7_scan_driver with SCAN_DIV=4.
// Expected outputs come from a behavioural model and go into a scoreboard queue
// as each stimulus cycle is driven. They are popped and compared after the clock edge.
module tb_seg7_scan_driver;

  localparam int unsigned DIV = 4;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic        load;
  logic [7:0]  digit_mask;
  logic [7:0]  dp_mask;
  logic        pending;
  logic        frame_tick;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg7_scan_driver #(.SCAN_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load       (load),
    .digit_mask (digit_mask),
    .dp_mask    (dp_mask),
    .pending    (pending),
    .frame_tick (frame_tick),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pend;
    logic       ft;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  // model state (edges since reset release, shadow, shown value, pending)
  int          m_cyc;
  logic [31:0] m_shadow;
  logic [31:0] m_disp;
  logic        m_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h (model cycle %0d)", tag, obs, exp, m_cyc);
    end
  endtask

  function automatic logic blank_of(input logic [31:0] v, input int d);
`ifdef SEG7_BLANK_LEADING_ZERO_EN
    int top;
    top = 0;
    for (int k = 0; k < 8; k++) if (((v >> (4 * k)) & 32'hF) != 0) top = k;
    return (d != 0) && (d > top);
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle of stimulus, queue the expected result, then compare after the edge
  task automatic step(input logic r, input logic ld, input logic [31:0] d);
    exp_t e;
    exp_t got;
    int   di;
    logic on;
    rst     = r;
    load    = ld;
    data_in = d;
    if (r) begin
      e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, pend: 1'b0, ft: 1'b0};
      m_cyc = 0; m_shadow = '0; m_disp = '0; m_pend = 1'b0;
    end else begin
      di    = (m_cyc / DIV) % 8;
      on    = digit_mask[di] && !blank_of(m_disp, di);
      e.an  = on ? ~(8'h01 << di) : 8'hFF;
      e.seg = HEX[(m_disp >> (4 * di)) & 32'hF];
      e.dp  = ~(dp_mask[di] & on);
      e.ft  = ((m_cyc % (8 * DIV)) == (8 * DIV - 1));
      if (e.ft && m_pend) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end
      if (ld) begin
        m_shadow = d;
        m_pend   = 1'b1;
      end
      e.pend = m_pend;
      m_cyc++;
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    got  = sb.pop_front();
    chk("an", 32'(an), 32'(got.an));
    chk("seg", 32'(seg), 32'(got.seg));
    chk("dp", 32'(dp), 32'(got.dp));
    chk("pending", 32'(pending), 32'(got.pend));
    chk("frame_tick", 32'(frame_tick), 32'(got.ft));
  endtask

  task automatic run_to(input int n);
    while (m_cyc < n) step(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data_in = '0;
    digit_mask = 8'hFF; dp_mask = 8'h00;
    m_cyc = 0; m_shadow = '0; m_disp = '0; m_pend = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_frame_tick", 32'(frame_tick), 32'h0);

    // first cycle after release shows digit 0 as "0"
    step(1'b0, 1'b0, 32'h0);
    chk("first_an", 32'(an), 32'hFE);
    chk("first_seg", 32'(seg), 32'h40);
    run_to(64);

    // mid-frame load waits for the frame boundary
    run_to(74);
    step(1'b0, 1'b1, 32'h0123_89AF);
    chk("load_pending", 32'(pending), 32'h1);
    run_to(97);
    chk("d0_seg", 32'(seg), 32'h0E);
    chk("d0_pending", 32'(pending), 32'h0);
    run_to(101);
    chk("d1_seg", 32'(seg), 32'h08);
    run_to(125);
    chk("d7_an", 32'(an), 32'h7F);
    chk("d7_seg", 32'(seg), 32'h40);

    // load on the frame_end cycle: shown value is the earlier shadow
    run_to(140);
    step(1'b0, 1'b1, 32'h1111_1111);
    run_to(159);
    step(1'b0, 1'b1, 32'h2222_2222);
    run_to(161);
    chk("fe_load_seg", 32'(seg), 32'h79);
    chk("fe_load_pending", 32'(pending), 32'h1);
    run_to(193);
    chk("fe_next_seg", 32'(seg), 32'h24);
    chk("fe_next_pending", 32'(pending), 32'h0);

    // digit and decimal-point masks
    digit_mask = 8'h0F; dp_mask = 8'h01;
    step(1'b0, 1'b0, 32'h0);
    chk("mask_dp0", 32'(dp), 32'h0);
    run_to(197);
    chk("mask_dp1", 32'(dp), 32'h1);
    run_to(209);
    chk("mask_an4", 32'(an), 32'hFF);
    run_to(234);

    // reset mid-frame restarts from digit 0
    step(1'b1, 1'b1, 32'hDEAD_BEEF);
    chk("mrst_an", 32'(an), 32'hFF);
    chk("mrst_seg", 32'(seg), 32'h7F);
    step(1'b0, 1'b0, 32'h0);
    chk("mrst_restart_an", 32'(an), 32'hFE);
    run_to(40);

    // leading-zero handling (blanked only when the option is built in)
    digit_mask = 8'hFF; dp_mask = 8'hFF;
    step(1'b0, 1'b1, 32'h0000_00A5);
    run_to(65);
    chk("a5_d0_seg", 32'(seg), 32'h12);
    run_to(69);
    chk("a5_d1_seg", 32'(seg), 32'h08);
    run_to(73);
`ifdef SEG7_BLANK_LEADING_ZERO_EN
    chk("a5_d2_blank_an", 32'(an), 32'hFF);
    chk("a5_d2_blank_dp", 32'(dp), 32'h1);
`else
    chk("a5_d2_an", 32'(an), 32'hFB);
`endif
    step(1'b0, 1'b1, 32'h0);
    run_to(97);
    chk("zero_d0_an", 32'(an), 32'hFE);
    chk("zero_d0_seg", 32'(seg), 32'h40);
    run_to(101);
`ifdef SEG7_BLANK_LEADING_ZERO_EN
    chk("zero_d1_blank_an", 32'(an), 32'hFF);
`else
    chk("zero_d1_an", 32'(an), 32'hFD);
`endif
    run_to(128);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
